// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern engine: pattern modes and step directions.
package led_pkg;

    localparam logic [1:0] MODE_ROT  = 2'd0;
    localparam logic [1:0] MODE_BNC  = 2'd1;
    localparam logic [1:0] MODE_FILL = 2'd2;
    localparam logic [1:0] MODE_CNT  = 2'd3;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/led_pattern_gen_if.sv
// Control and LED-drive bundle between a demo top and the pattern engine.
interface led_pattern_gen_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic [1:0]       mode;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] led;
  logic             step;
  logic             wrap;

  modport master (output en, mode, dir, load, seed, input led, step, wrap);
  modport slave  (input en, mode, dir, load, seed, output led, step, wrap);
endinterface

// File: rtl/led_tick_gen.sv
// Step prescaler: tick for one cycle every DIV enabled cycles; en=0 holds the count.
// Latency: tick is combinational from the count; clr restarts the period.
module led_tick_gen #(
  parameter int DIV   = 3_000_000,
  parameter int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: rotate / bounce / fill-drain / count, one step per DIV enabled cycles.
// Outputs registered, updated on the tick edge; en=0 pauses without losing the count, load wins over tick.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIV   = 3_000_000,
  parameter int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input logic               clk,
  input logic               rst_n,
  led_pattern_gen_if.slave  bus
);
  localparam logic [WIDTH-1:0] LED_ONE = WIDTH'(1);

  logic             tick;
  logic [WIDTH-1:0] led_q, led_nxt;
  logic             bdir_q, bdir_nxt;
  logic             fph_q, fph_nxt;
  logic             step_q, step_nxt;
  logic             wrap_q, wrap_nxt;
  logic [WIDTH-1:0] shl, shr, fill_res;

  led_tick_gen #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .clr   (bus.load),
    .tick  (tick)
  );

  assign shl = {led_q[WIDTH-2:0], 1'b0};
  assign shr = {1'b0, led_q[WIDTH-1:1]};

  always_comb begin
    led_nxt  = led_q;
    bdir_nxt = bdir_q;
    fph_nxt  = fph_q;
    step_nxt = 1'b0;
    wrap_nxt = 1'b0;
    fill_res = '0;
    if (bus.load) begin
      led_nxt  = bus.seed;
      fph_nxt  = 1'b0;
      bdir_nxt = bus.dir;
    end else if (tick) begin
      step_nxt = 1'b1;
      case (bus.mode)
        MODE_ROT: begin
          if (led_q == '0) begin
            led_nxt = LED_ONE;
          end else if (bus.dir == DIR_UP) begin
            led_nxt  = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
            wrap_nxt = led_q[WIDTH-1];
          end else begin
            led_nxt  = {led_q[0], led_q[WIDTH-1:1]};
            wrap_nxt = led_q[0];
          end
        end
        MODE_BNC: begin
          // Reversal happens in the same step that hits the end bit.
          if (led_q == '0) begin
            led_nxt = LED_ONE;
          end else if (bdir_q == DIR_UP) begin
            if (led_q[WIDTH-1]) begin
              bdir_nxt = DIR_DN;
              led_nxt  = shr;
              wrap_nxt = 1'b1;
            end else begin
              led_nxt = shl;
            end
          end else begin
            if (led_q[0]) begin
              bdir_nxt = DIR_UP;
              led_nxt  = shl;
              wrap_nxt = 1'b1;
            end else begin
              led_nxt = shr;
            end
          end
        end
        MODE_FILL: begin
          fill_res = (bus.dir == DIR_UP) ? {led_q[WIDTH-2:0], ~fph_q}
                                         : {~fph_q, led_q[WIDTH-1:1]};
          led_nxt  = fill_res;
          if (!fph_q && (&fill_res)) begin
            fph_nxt = 1'b1;
          end else if (fph_q && !(|fill_res)) begin
            fph_nxt  = 1'b0;
            wrap_nxt = 1'b1;
          end
        end
        MODE_CNT: begin
          if (bus.dir == DIR_UP) begin
            led_nxt  = led_q + LED_ONE;
            wrap_nxt = &led_q;
          end else begin
            led_nxt  = led_q - LED_ONE;
            wrap_nxt = !(|led_q);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_q  <= LED_ONE;
      bdir_q <= DIR_UP;
      fph_q  <= 1'b0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      led_q  <= led_nxt;
      bdir_q <= bdir_nxt;
      fph_q  <= fph_nxt;
      step_q <= step_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  assign bus.led  = led_q;
  assign bus.step = step_q;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen at WIDTH=8, DIV=4: directed step table, corner sequences, random run vs model.
module tb_led_pattern_gen;
  localparam int W   = 8;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  led_pattern_gen_if #(.WIDTH(W)) bus ();

  led_pattern_gen #(.WIDTH(W), .DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    bit       ld;
    bit [1:0] mode;
    bit       dir;
    bit [7:0] val;
    bit       wrap;
  } vec_t;

  vec_t vt[$];

  task automatic add(bit ld, bit [1:0] mode, bit dir, bit [7:0] val, bit wrap);
    vec_t v;
    v.ld = ld; v.mode = mode; v.dir = dir; v.val = val; v.wrap = wrap;
    vt.push_back(v);
  endtask

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  // Cycles until the next step pulse, bounded.
  task automatic do_step(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick_clk();
      n++;
      if (bus.step) break;
    end
  endtask

  task automatic do_load(bit [1:0] mode, bit dir, bit [7:0] seed);
    bus.mode = mode; bus.dir = dir; bus.seed = seed; bus.load = 1'b1;
    tick_clk();
    bus.load = 1'b0;
  endtask

  // Reference model state
  int m_led, m_cnt;
  bit m_bdir, m_fph, m_step, m_wrap;

  task automatic model_edge(bit r, bit en, bit ld, bit [1:0] mode, bit dir, bit [7:0] seed);
    int b;
    m_step = 0; m_wrap = 0;
    if (!r) begin
      m_led = 1; m_cnt = 0; m_bdir = 0; m_fph = 0;
    end else if (ld) begin
      m_led = seed; m_cnt = 0; m_fph = 0; m_bdir = dir;
    end else if (en && m_cnt < DIV - 1) begin
      m_cnt++;
    end else if (en) begin
      m_cnt = 0; m_step = 1;
      if (mode == 0) begin
        if (m_led == 0) m_led = 1;
        else if (dir == 0) begin m_wrap = (m_led >= 128); m_led = (m_led * 2) % 256 + m_led / 128; end
        else begin m_wrap = (m_led % 2 == 1); m_led = m_led / 2 + (m_led % 2) * 128; end
      end else if (mode == 1) begin
        if (m_led == 0) m_led = 1;
        else if (m_bdir == 0 && m_led >= 128) begin m_bdir = 1; m_wrap = 1; m_led = m_led / 2; end
        else if (m_bdir == 0) m_led = (m_led * 2) % 256;
        else if (m_led % 2 == 1) begin m_bdir = 0; m_wrap = 1; m_led = (m_led * 2) % 256; end
        else m_led = m_led / 2;
      end else if (mode == 2) begin
        b = m_fph ? 0 : 1;
        m_led = (dir == 0) ? (m_led * 2) % 256 + b : m_led / 2 + b * 128;
        if (!m_fph && m_led == 255) m_fph = 1;
        else if (m_fph && m_led == 0) begin m_fph = 0; m_wrap = 1; end
      end else begin
        m_wrap = (dir == 0) ? (m_led == 255) : (m_led == 0);
        m_led = (dir == 0) ? (m_led + 1) % 256 : (m_led + 255) % 256;
      end
    end
  endtask

  initial begin
    int n;
    bit held_ok;
    bit r, en, ld, dir;
    bit [1:0] mode;
    bit [7:0] seed;

    // Rotate up from reset
    for (int i = 1; i <= 7; i++) add(0, 0, 0, 8'(1 << i), 0);
    add(0, 0, 0, 8'h01, 1);
    // Bounce from 0x40
    add(1, 1, 0, 8'h40, 0);
    add(0, 1, 0, 8'h80, 0);
    add(0, 1, 0, 8'h40, 1);
    add(0, 1, 0, 8'h20, 0); add(0, 1, 0, 8'h10, 0); add(0, 1, 0, 8'h08, 0);
    add(0, 1, 0, 8'h04, 0); add(0, 1, 0, 8'h02, 0); add(0, 1, 0, 8'h01, 0);
    add(0, 1, 0, 8'h02, 1);
    // Fill then drain from 0x00
    add(1, 2, 0, 8'h00, 0);
    add(0, 2, 0, 8'h01, 0); add(0, 2, 0, 8'h03, 0); add(0, 2, 0, 8'h07, 0); add(0, 2, 0, 8'h0F, 0);
    add(0, 2, 0, 8'h1F, 0); add(0, 2, 0, 8'h3F, 0); add(0, 2, 0, 8'h7F, 0); add(0, 2, 0, 8'hFF, 0);
    add(0, 2, 0, 8'hFE, 0); add(0, 2, 0, 8'hFC, 0); add(0, 2, 0, 8'hF8, 0); add(0, 2, 0, 8'hF0, 0);
    add(0, 2, 0, 8'hE0, 0); add(0, 2, 0, 8'hC0, 0); add(0, 2, 0, 8'h80, 0); add(0, 2, 0, 8'h00, 1);
    add(0, 2, 0, 8'h01, 0);
    // Count down through zero
    add(1, 3, 1, 8'h01, 0);
    add(0, 3, 1, 8'h00, 0); add(0, 3, 1, 8'hFF, 1); add(0, 3, 1, 8'hFE, 0);
    // Rotate zero recovery, rotate down with wrap
    add(1, 0, 0, 8'h00, 0);
    add(0, 0, 0, 8'h01, 0);
    add(1, 0, 1, 8'h01, 0);
    add(0, 0, 1, 8'h80, 1); add(0, 0, 1, 8'h40, 0);

    rst_n = 1'b0; bus.en = 1'b1; bus.mode = 2'd0; bus.dir = 1'b0;
    bus.load = 1'b0; bus.seed = '0;
    tick_clk(); tick_clk();
    check("reset_led", bus.led, 8'h01);
    check("reset_step", bus.step, 0);
    check("reset_wrap", bus.wrap, 0);
    rst_n = 1'b1;

    foreach (vt[k]) begin
      if (vt[k].ld) begin
        do_load(vt[k].mode, vt[k].dir, vt[k].val);
        check($sformatf("vec%0d_load_led", k), bus.led, vt[k].val);
        check($sformatf("vec%0d_load_step", k), bus.step, 0);
      end else begin
        bus.mode = vt[k].mode; bus.dir = vt[k].dir;
        do_step(n);
        check($sformatf("vec%0d_period", k), n, DIV);
        check($sformatf("vec%0d_led", k), bus.led, vt[k].val);
        check($sformatf("vec%0d_wrap", k), bus.wrap, vt[k].wrap);
      end
    end

    // Pause mid-period: step arrives 10 cycles late, nothing moves meanwhile
    do_load(0, 0, 8'h01);
    tick_clk(); tick_clk();
    bus.en = 1'b0;
    held_ok = 1;
    for (int i = 0; i < 10; i++) begin
      tick_clk();
      if (bus.step || bus.led != 8'h01) held_ok = 0;
    end
    check("pause_hold", held_ok, 1);
    bus.en = 1'b1;
    do_step(n);
    check("pause_resume_cycles", n, 2);
    check("pause_resume_led", bus.led, 8'h02);

    // Load on the tick cycle wins
    do_load(0, 0, 8'h01);
    tick_clk(); tick_clk(); tick_clk();
    bus.load = 1'b1; bus.seed = 8'h5A;
    tick_clk();
    bus.load = 1'b0;
    check("load_vs_tick_led", bus.led, 8'h5A);
    check("load_vs_tick_step", bus.step, 0);
    do_step(n);
    check("load_vs_tick_period", n, DIV);
    check("load_vs_tick_next", bus.led, 8'hB4);

    // Reset on the would-be tick edge aborts the step
    do_load(1, 0, 8'h10);
    tick_clk(); tick_clk(); tick_clk();
    rst_n = 1'b0;
    tick_clk();
    rst_n = 1'b1;
    check("midrst_led", bus.led, 8'h01);
    check("midrst_step", bus.step, 0);
    check("midrst_wrap", bus.wrap, 0);
    do_step(n);
    check("midrst_period", n, DIV);
    check("midrst_next", bus.led, 8'h02);

    // Random run against the model
    rst_n = 1'b0;
    tick_clk();
    model_edge(0, 1, 0, 0, 0, 0);
    mode = 0; dir = 0;
    for (int c = 0; c < 3000; c++) begin
      r    = ($urandom % 200) != 0;
      en   = ($urandom % 8) != 0;
      ld   = ($urandom % 40) == 0;
      seed = 8'($urandom);
      if ($urandom % 16 == 0) mode = 2'($urandom);
      if ($urandom % 16 == 0) dir  = 1'($urandom);
      rst_n = r; bus.en = en; bus.load = ld; bus.seed = seed;
      bus.mode = mode; bus.dir = dir;
      tick_clk();
      model_edge(r, en, ld, mode, dir, seed);
      check($sformatf("rand%0d_led", c), bus.led, m_led);
      check($sformatf("rand%0d_step", c), bus.step, m_step);
      check($sformatf("rand%0d_wrap", c), bus.wrap, m_wrap);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern engine driving the board LED bank. It generalises the fixed 16-bit rotator into WIDTH bits with a built-in step prescaler and four modes: rotate, bounce, fill/drain and binary count. It also supports seed load and pause. It sits between the board clock and the LED pins and is the standard LED driver for all future demo tops.

## Interface
- WIDTH, 16: number of LEDs (≥2)
- DIV, 3_000_000: clk cycles per pattern step (≥1)
- CNT_W, $clog2(DIV) (min 1): prescaler counter width, derived
---
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset: one clock; reset is synchronous and active-low
- en  in  1  1 = run prescaler and steps; 0 = pause (state held)
- mode  in  2  pattern select (encodings in led_pkg)
- dir  in  1  0 = toward MSB / up, 1 = toward LSB / down
- load  in  1  synchronous seed load, one-cycle pulse or level
- seed  in  WIDTH  value loaded on load
- led  out  WIDTH  LED drive, registered
- step  out  1  one-cycle pulse in the cycle led shows a new step value
- wrap  out  1  one-cycle pulse with step when the pattern completes a cycle

## Operation
- Reset (rst_n=0 at edge): led=1 (LSB only), prescaler=0, bounce_dir=up, fill_ph=0, step=0, wrap=0.
- Prescaler counts 0..DIV-1 while en=1. tick is internal, asserted when cnt==DIV-1 and en=1, and cnt wraps to 0. With en=0 the counter holds. DIV=1 gives tick every enabled cycle.
- Priority: rst_n > load > tick.
  - load: led<=seed, cnt<=0, fill_ph<=0, bounce_dir<=dir, no step/wrap.
- On tick, by mode:
  - ROTATE (0): dir=0: led<={led[W-2:0],led[W-1]}; dir=1: led<={led[0],led[W-1:1]}. wrap when the shifted-out end bit was 1.
  - BOUNCE (1): zero-fill shift in bounce_dir. If bounce_dir=up and led[W-1]=1, flip to down and shift down in the same step (wrap=1). The mirror case applies at led[0]. dir is ignored except at load.
  - FILL (2): fill_ph=0 shifts in 1 (at LSB if dir=0, MSB if dir=1). When the result is all ones, fill_ph<=1. fill_ph=1 shifts in 0; when the result is all zeros, fill_ph<=0 and wrap=1.
  - COUNT (3): led<=led+1 (dir=0) or led-1 (dir=1), mod 2^WIDTH. wrap on all-ones→0 or 0→all-ones.
- Zero recovery: in ROTATE/BOUNCE, a tick with led==0 loads led<=1 instead of shifting.
- mode/dir changes are sampled only at a tick, so there is no glitch mid-step. A mode change keeps led and starts the new mode from that value.
- rst_n low mid-step aborts the step. The reset values appear the cycle after the edge.

## Timing
- led, step and wrap are registered and update on the edge where tick=1. Latency from cnt==DIV-1 to new led is one edge.
- Step period is exactly DIV cycles of en=1. Pausing stretches the period by the number of paused cycles; the count is not lost.
- load: led=seed visible the cycle after the load edge. The next step follows DIV enabled cycles later.
- load with a simultaneous tick: the load wins and no step is issued.

## Structure
- Package led_pkg holds:
  - mode localparams MODE_ROT=2'd0, MODE_BNC=2'd1, MODE_FILL=2'd2, MODE_CNT=2'd3
  - direction constants DIR_UP=1'b0, DIR_DN=1'b1
- One sub-module, led_tick_gen (params DIV, CNT_W; ports clk, rst_n, en, clr, tick), owns the prescaler and is reused elsewhere.
- The pattern next-state logic is one combinational case on mode feeding registered led/bounce_dir/fill_ph/step/wrap.

## Test plan
Use WIDTH=8, DIV=4 throughout.
- Reset then ROTATE, dir=0, en=1 → led 0x01, 0x02, 0x04 … at 4-cycle spacing; 0x80→0x01 with wrap=1; step high exactly 1 cycle per 4.
- BOUNCE from seed 0x40, dir=0 → 0x80, 0x40 (wrap on the reversal), 0x20 … 0x01, 0x02 (wrap).
- FILL, dir=0 from 0x00 → 0x01, 0x03 … 0xFF, then 0xFE, 0xFC … 0x00 with wrap=1, then 0x01.
- COUNT, dir=1 from seed 0x01 → 0x00, 0xFF (wrap=1), 0xFE.
- en low for 10 cycles mid-period → no step, led unchanged; the step lands 10 cycles late. load=1 coinciding with a tick → led=seed, step=0.
- rst_n low for 1 cycle mid-run in any mode → led=0x01, step=0, next step exactly 4 cycles after release. ROTATE with seed 0x00 → next step gives 0x01.
